// File: rtl/fetch_target_queue_pkg.sv
// Shared frontend types for the fetch target queue: entry, resolve and BPU update
// payloads, plus the helper that turns a committed entry into a BPU update.
package fetch_target_queue_pkg;

    localparam int FTQ_DEPTH = 8;
    localparam int FTQ_IDX_W = $clog2(FTQ_DEPTH);

    typedef logic [FTQ_IDX_W-1:0] ftqIdx_t;
    typedef logic [FTQ_IDX_W:0]   ftqPtr_t;

    typedef struct packed {
        logic [31:0] startAddr;
        logic [31:0] predTarget;
        logic        predTaken;
        logic [1:0]  ftb_counter;
    } ftqInfo_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] targetAddr;
        logic        mispred;
    } ftqResolve_t;

    typedef struct packed {
        logic [1:0]  counter;
        logic        taken;
        logic [31:0] targetAddr;
        logic        mispred;
    } ftbUpdate_t;

    typedef struct packed {
        logic [31:0] startAddr;
        ftbUpdate_t  ftb_update;
    } BPupdateInfo_t;

    // Saturating 2-bit counter trained toward the resolved direction.
    function automatic BPupdateInfo_t genUpdate(input ftqInfo_t entry, input ftqResolve_t res);
        BPupdateInfo_t upd;
        upd.startAddr             = entry.startAddr;
        upd.ftb_update.taken      = res.taken;
        upd.ftb_update.targetAddr = res.targetAddr;
        upd.ftb_update.mispred    = res.mispred;
        if (res.taken) begin
            upd.ftb_update.counter = (entry.ftb_counter == 2'd3) ? 2'd3 : entry.ftb_counter + 2'd1;
        end else begin
            upd.ftb_update.counter = (entry.ftb_counter == 2'd0) ? 2'd0 : entry.ftb_counter - 2'd1;
        end
        return upd;
    endfunction

endpackage

// File: rtl/fetch_target_queue_ptr.sv
// Wrap-bit ring pointer helper: increment modulo 2*DEPTH and split comparison
// (index bits vs. wrap bit) so callers can derive empty/full/equal.
module fetch_target_queue_ptr #(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH) + 1
) (
    input  logic [PW-1:0] ptr_i,
    input  logic [PW-1:0] ref_i,
    output logic [PW-1:0] inc_o,
    output logic          idx_eq_o,
    output logic          wrap_eq_o
);

    assign inc_o     = ptr_i + PW'(1);
    assign idx_eq_o  = (ptr_i[PW-2:0] == ref_i[PW-2:0]);
    assign wrap_eq_o = (ptr_i[PW-1] == ref_i[PW-1]);

endmodule

// File: rtl/fetch_target_queue.sv
// Fetch target queue: in-order ring of BPU predictions between enqueue, fetch and
// commit pointers, with squash truncation and a one-at-a-time BPU update handshake.
module fetch_target_queue
    import fetch_target_queue_pkg::*;
#(
    parameter int DEPTH = FTQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_pred_vld,
    input  ftqInfo_t                   i_pred_ftqInfo,
    output logic                       o_ftq_rdy,
    output logic                       o_fetch_vld,
    output ftqInfo_t                   o_fetch_ftqInfo,
    output logic [$clog2(DEPTH)-1:0]   o_fetch_ftqIdx,
    input  logic                       i_fetch_rdy,
    input  logic                       i_squash_vld,
    input  logic [$clog2(DEPTH)-1:0]   i_squash_ftqIdx,
    input  logic                       i_commit_vld,
    input  ftqResolve_t                i_commit_resolve,
    output logic                       o_commit_rdy,
    output logic                       o_update_vld,
    output BPupdateInfo_t              o_BPupdateInfo,
    input  logic                       i_update_finished
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_UPDATE = 1'b1;

    logic [PW-1:0] enq_q, enq_d, fetch_q, fetch_d, cmt_q, cmt_d;
    logic [0:0]    state_q, state_d;
    BPupdateInfo_t upd_q, upd_d;
    ftqInfo_t      mem_q [DEPTH];
    logic          mem_we;

    logic [PW-1:0] enq_inc, fetch_inc, cmt_inc;
    logic          ec_idx_eq, ec_wrap_eq;
    logic          fe_idx_eq, fe_wrap_eq;
    logic          cf_idx_eq, cf_wrap_eq;

    fetch_target_queue_ptr #(.DEPTH(DEPTH)) u_enq_ptr (
        .ptr_i(enq_q), .ref_i(cmt_q), .inc_o(enq_inc),
        .idx_eq_o(ec_idx_eq), .wrap_eq_o(ec_wrap_eq)
    );
    fetch_target_queue_ptr #(.DEPTH(DEPTH)) u_fetch_ptr (
        .ptr_i(fetch_q), .ref_i(enq_q), .inc_o(fetch_inc),
        .idx_eq_o(fe_idx_eq), .wrap_eq_o(fe_wrap_eq)
    );
    fetch_target_queue_ptr #(.DEPTH(DEPTH)) u_cmt_ptr (
        .ptr_i(cmt_q), .ref_i(fetch_q), .inc_o(cmt_inc),
        .idx_eq_o(cf_idx_eq), .wrap_eq_o(cf_wrap_eq)
    );

    logic full, enq_fire, fetch_fire, cmt_at_fetch;
    assign full         = ec_idx_eq && !ec_wrap_eq;
    assign cmt_at_fetch = cf_idx_eq && cf_wrap_eq;

    assign o_ftq_rdy       = !full;
    assign o_fetch_vld     = !(fe_idx_eq && fe_wrap_eq);
    assign o_fetch_ftqIdx  = fetch_q[IW-1:0];
    assign o_fetch_ftqInfo = mem_q[fetch_q[IW-1:0]];
    assign o_BPupdateInfo  = upd_q;

    assign enq_fire   = i_pred_vld && o_ftq_rdy;
    assign fetch_fire = o_fetch_vld && i_fetch_rdy;

    // Rebuild the full pointer of the squashed index as its ring offset from cmt.
    logic [IW-1:0] sq_off;
    logic [PW-1:0] occupancy, sq_next;
    logic          sq_hit;
    assign sq_off    = i_squash_ftqIdx - cmt_q[IW-1:0];
    assign occupancy = enq_q - cmt_q;
    assign sq_hit    = i_squash_vld && (PW'(sq_off) < occupancy);
    assign sq_next   = cmt_q + PW'(sq_off) + PW'(1);

    always_comb begin
        enq_d        = enq_q;
        fetch_d      = fetch_q;
        cmt_d        = cmt_q;
        state_d      = state_q;
        upd_d        = upd_q;
        mem_we       = 1'b0;
        o_commit_rdy = 1'b0;
        o_update_vld = 1'b0;

        if (sq_hit) begin
            enq_d   = sq_next;
            fetch_d = sq_next;
        end else begin
            if (enq_fire) begin
                enq_d  = enq_inc;
                mem_we = 1'b1;
            end
            if (fetch_fire) begin
                fetch_d = fetch_inc;
            end
        end

        case (state_q)
            ST_IDLE: begin
                o_commit_rdy = !cmt_at_fetch;
                if (i_commit_vld && o_commit_rdy) begin
                    upd_d   = genUpdate(mem_q[cmt_q[IW-1:0]], i_commit_resolve);
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                o_update_vld = 1'b1;
                if (i_update_finished) begin
                    cmt_d   = cmt_inc;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enq_q   <= '0;
            fetch_q <= '0;
            cmt_q   <= '0;
            state_q <= ST_IDLE;
            upd_q   <= '0;
        end else begin
            enq_q   <= enq_d;
            fetch_q <= fetch_d;
            cmt_q   <= cmt_d;
            state_q <= state_d;
            upd_q   <= upd_d;
        end
    end

    // Payload storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[enq_q[IW-1:0]] <= i_pred_ftqInfo;
        end
    end

endmodule
